// File: rtl/mole_round_engine.sv
// rtl/mole_round_engine.sv - whack-a-mole round engine
// Pops LFSR-chosen moles while playing, scores hits and counts misses.
module mole_round_engine #(
  parameter int NUM_HOLES     = 8,
  parameter int MOLE_UP_TICKS = 1000,
  parameter int GAP_TICKS     = 250,
  parameter int SCORE_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [1:0]           game_begin,
  input  logic [NUM_HOLES-1:0] whack,
  output logic [NUM_HOLES-1:0] mole_leds,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses,
  output logic                 hit_pulse,
  output logic                 game_over
);
  localparam int HW   = $clog2(NUM_HOLES);
  localparam int MAXT = (MOLE_UP_TICKS > GAP_TICKS) ? MOLE_UP_TICKS : GAP_TICKS;
  localparam int CW   = $clog2(MAXT + 1);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_UP, S_DONE} state_t;

  state_t               r_state;
  logic [15:0]          r_lfsr;
  logic [NUM_HOLES-1:0] r_whack_q;
  logic [CW-1:0]        r_cnt;
  logic [HW-1:0]        r_hole;
  logic [NUM_HOLES-1:0] r_mole_leds;
  logic [SCORE_W-1:0]   r_score;
  logic [SCORE_W-1:0]   r_misses;
  logic                 r_hit_pulse;
  logic                 r_game_over;

  logic                 w_fb;
  logic [NUM_HOLES-1:0] w_press;
  logic [HW-1:0]        w_cand;
  logic [HW-1:0]        w_next_hole;
  logic [NUM_HOLES-1:0] w_mole_mask;
  logic                 w_wrong;
  logic                 w_right;
  logic [SCORE_W-1:0]   w_score_inc;
  logic [SCORE_W-1:0]   w_miss_inc;

  assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_press     = whack & ~r_whack_q;
  assign w_cand      = r_lfsr[HW-1:0];
  // Never pop the same hole twice in a row; HW-bit add wraps modulo NUM_HOLES.
  assign w_next_hole = (w_cand == r_hole) ? w_cand + HW'(1) : w_cand;
  assign w_mole_mask = NUM_HOLES'(1) << r_hole;
  assign w_wrong     = |(w_press & ~w_mole_mask);
  assign w_right     = |(w_press & w_mole_mask);
  assign w_score_inc = (&r_score)  ? r_score  : r_score  + SCORE_W'(1);
  assign w_miss_inc  = (&r_misses) ? r_misses : r_misses + SCORE_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_lfsr      <= 16'hACE1;
      r_whack_q   <= '0;
      r_cnt       <= '0;
      r_hole      <= '0;
      r_mole_leds <= '0;
      r_score     <= '0;
      r_misses    <= '0;
      r_hit_pulse <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_lfsr      <= {r_lfsr[14:0], w_fb};
      r_whack_q   <= whack;
      r_hit_pulse <= 1'b0;
      if (game_begin[1]) begin
        r_state     <= S_DONE;
        r_mole_leds <= '0;
        r_game_over <= 1'b1;
      end else if (game_begin == 2'b00) begin
        r_state     <= S_IDLE;
        r_mole_leds <= '0;
        r_game_over <= 1'b0;
        r_score     <= '0;
        r_misses    <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_GAP;
            r_cnt   <= CW'(GAP_TICKS);
          end
          S_GAP: begin
            if (tick) begin
              if (r_cnt <= CW'(1)) begin
                r_state     <= S_UP;
                r_hole      <= w_next_hole;
                r_mole_leds <= NUM_HOLES'(1) << w_next_hole;
                r_cnt       <= CW'(MOLE_UP_TICKS);
              end else begin
                r_cnt <= r_cnt - CW'(1);
              end
            end
          end
          S_UP: begin
            // Wrong press beats a right press, which beats a timeout.
            if (w_wrong || w_right || (tick && r_cnt <= CW'(1))) begin
              r_state     <= S_GAP;
              r_cnt       <= CW'(GAP_TICKS);
              r_mole_leds <= '0;
              if (!w_wrong && w_right) begin
                r_score     <= w_score_inc;
                r_hit_pulse <= 1'b1;
              end else begin
                r_misses <= w_miss_inc;
              end
            end else if (tick) begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          default: r_state <= S_DONE;
        endcase
      end
    end
  end

  assign mole_leds = r_mole_leds;
  assign score     = r_score;
  assign misses    = r_misses;
  assign hit_pulse = r_hit_pulse;
  assign game_over = r_game_over;
endmodule

// File: tb/tb_mole_round_engine.sv
// tb/tb_mole_round_engine.sv - self-checking bench for mole_round_engine
// Scenario tasks with a score/miss model kept as plain arithmetic.
module tb_mole_round_engine;
  localparam int NH    = 8;
  localparam int UP_T  = 4;
  localparam int GAP_T = 2;
  localparam int SW    = 8;
  localparam int SMAX  = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic [1:0]    game_begin;
  logic [NH-1:0] whack;
  logic [NH-1:0] mole_leds;
  logic [SW-1:0] score;
  logic [SW-1:0] misses;
  logic          hit_pulse;
  logic          game_over;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_score = 0;
  int exp_misses = 0;
  int last_hole = -1;
  int cur_hole = 0;

  mole_round_engine #(
    .NUM_HOLES(NH), .MOLE_UP_TICKS(UP_T), .GAP_TICKS(GAP_T), .SCORE_W(SW)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .game_begin(game_begin), .whack(whack),
    .mole_leds(mole_leds), .score(score), .misses(misses),
    .hit_pulse(hit_pulse), .game_over(game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int hole_of(input logic [NH-1:0] v);
    int r;
    r = -1;
    if ($onehot(v)) for (int i = 0; i < NH; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= SMAX) ? SMAX : v + 1;
  endfunction

  // Waits for the next mole; it must appear after exactly exp_steps edges.
  task automatic wait_mole(input int exp_steps);
    int n;
    int h;
    n = 0;
    do begin
      step();
      n++;
    end while (mole_leds == '0 && n < 20);
    h = hole_of(mole_leds);
    n_cmp++;
    if (n !== exp_steps) begin
      n_bad++;
      $display("FAIL gap_len: got %0d edges, expected %0d", n, exp_steps);
    end
    n_cmp++;
    if (h < 0) begin
      n_bad++;
      $display("FAIL mole_onehot: got leds %b, expected one-hot", mole_leds);
    end
    if (last_hole >= 0) begin
      n_cmp++;
      if (h == last_hole) begin
        n_bad++;
        $display("FAIL mole_repeat: got hole %0d, expected different from %0d", h, last_hole);
      end
    end
    cur_hole  = (h < 0) ? 0 : h;
    last_hole = cur_hole;
  endtask

  task automatic test_reset();
    reset = 1'b0; tick = 1'b1; game_begin = 2'b01; whack = '0;
    #3;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({mole_leds, score, misses, hit_pulse, game_over} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs: got leds=%b score=%0d misses=%0d hit=%b go=%b, expected all 0",
                 mole_leds, score, misses, hit_pulse, game_over);
      end
    end
  endtask

  task automatic test_first_mole();
    reset = 1'b1;
    last_hole = -1; exp_score = 0; exp_misses = 0;
    wait_mole(GAP_T + 1);
    n_cmp++;
    if (score !== SW'(0) || misses !== SW'(0)) begin
      n_bad++;
      $display("FAIL first_mole_counts: got score=%0d misses=%0d, expected 0/0", score, misses);
    end
  endtask

  task automatic test_hit_and_hold();
    whack = '0;
    whack[cur_hole] = 1'b1;
    step();
    exp_score = sat_inc(exp_score);
    n_cmp++;
    if (score !== SW'(exp_score) || hit_pulse !== 1'b1 || mole_leds !== '0) begin
      n_bad++;
      $display("FAIL hit: got score=%0d hit=%b leds=%b, expected score=%0d hit=1 leds=0",
               score, hit_pulse, mole_leds, exp_score);
    end
    step();
    n_cmp++;
    if (hit_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL hit_width: got hit=%b, expected 0 on second cycle", hit_pulse);
    end
    wait_mole(GAP_T - 1);
    for (int i = 0; i < UP_T; i++) begin
      step();
      n_cmp++;
      if (hit_pulse !== 1'b0 || score !== SW'(exp_score)) begin
        n_bad++;
        $display("FAIL held_button: got hit=%b score=%0d, expected hit=0 score=%0d",
                 hit_pulse, score, exp_score);
      end
    end
    exp_misses = sat_inc(exp_misses);
    n_cmp++;
    if (mole_leds !== '0 || misses !== SW'(exp_misses)) begin
      n_bad++;
      $display("FAIL held_timeout: got leds=%b misses=%0d, expected leds=0 misses=%0d",
               mole_leds, misses, exp_misses);
    end
    whack = '0;
  endtask

  task automatic test_timeout();
    int k;
    wait_mole(GAP_T);
    k = $urandom_range(1, 3);
    tick = 1'b0;
    for (int i = 0; i < k + UP_T - 1; i++) begin
      if (i == k) tick = 1'b1;
      step();
      n_cmp++;
      if (mole_leds !== (NH'(1) << cur_hole)) begin
        n_bad++;
        $display("FAIL mole_stays_up: got leds=%b at edge %0d, expected hole %0d lit", mole_leds, i, cur_hole);
      end
    end
    step();
    exp_misses = sat_inc(exp_misses);
    n_cmp++;
    if (mole_leds !== '0 || misses !== SW'(exp_misses) || score !== SW'(exp_score)) begin
      n_bad++;
      $display("FAIL timeout: got leds=%b misses=%0d score=%0d, expected 0/%0d/%0d",
               mole_leds, misses, score, exp_misses, exp_score);
    end
  endtask

  task automatic test_simultaneous();
    int o;
    wait_mole(GAP_T);
    o = (cur_hole + 1 + $urandom_range(0, NH - 2)) % NH;
    whack = '0;
    whack[cur_hole] = 1'b1;
    whack[o] = 1'b1;
    step();
    exp_misses = sat_inc(exp_misses);
    n_cmp++;
    if (misses !== SW'(exp_misses) || score !== SW'(exp_score) || hit_pulse !== 1'b0 || mole_leds !== '0) begin
      n_bad++;
      $display("FAIL simultaneous: got misses=%0d score=%0d hit=%b leds=%b, expected %0d/%0d/0/0",
               misses, score, hit_pulse, mole_leds, exp_misses, exp_score);
    end
    whack = '0;
  endtask

  task automatic test_random(input int rounds);
    int act;
    int d;
    int o;
    for (int r = 0; r < rounds; r++) begin
      wait_mole(GAP_T);
      act = $urandom_range(0, 3);
      d = (act == 2) ? 0 : $urandom_range(0, 2);
      repeat (d) step();
      whack = '0;
      o = (cur_hole + 1 + $urandom_range(0, NH - 2)) % NH;
      case (act)
        0: begin whack[cur_hole] = 1'b1; step(); exp_score = sat_inc(exp_score); end
        1: begin whack[o] = 1'b1; step(); exp_misses = sat_inc(exp_misses); end
        2: begin repeat (UP_T) step(); exp_misses = sat_inc(exp_misses); end
        default: begin
          whack[cur_hole] = 1'b1; whack[o] = 1'b1;
          step();
          exp_misses = sat_inc(exp_misses);
        end
      endcase
      n_cmp++;
      if (score !== SW'(exp_score) || misses !== SW'(exp_misses) || mole_leds !== '0 ||
          hit_pulse !== (act == 0)) begin
        n_bad++;
        $display("FAIL random_round%0d act%0d: got score=%0d misses=%0d leds=%b hit=%b, expected %0d/%0d/0/%0d",
                 r, act, score, misses, mole_leds, hit_pulse, exp_score, exp_misses, (act == 0));
      end
      whack = '0;
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      wait_mole(GAP_T);
      whack = '0;
      whack[cur_hole] = 1'b1;
      step();
      exp_score = sat_inc(exp_score);
      n_cmp++;
      if (score !== SW'(exp_score)) begin
        n_bad++;
        $display("FAIL sat_hit%0d: got score=%0d, expected %0d", i, score, exp_score);
      end
      whack = '0;
    end
    n_cmp++;
    if (score !== SW'(SMAX) || misses !== SW'(exp_misses)) begin
      n_bad++;
      $display("FAIL saturation: got score=%0d misses=%0d, expected %0d/%0d", score, misses, SMAX, exp_misses);
    end
  endtask

  task automatic test_phase_override();
    wait_mole(GAP_T);
    whack = '0;
    whack[cur_hole] = 1'b1;
    game_begin = 2'b10;
    step();
    n_cmp++;
    if (mole_leds !== '0 || game_over !== 1'b1 || hit_pulse !== 1'b0 ||
        score !== SW'(exp_score) || misses !== SW'(exp_misses)) begin
      n_bad++;
      $display("FAIL game_over_entry: got leds=%b go=%b hit=%b score=%0d misses=%0d, expected 0/1/0/%0d/%0d",
               mole_leds, game_over, hit_pulse, score, misses, exp_score, exp_misses);
    end
    for (int i = 0; i < 6; i++) begin
      whack = NH'($urandom);
      game_begin = 2'($urandom_range(1, 3));
      step();
      n_cmp++;
      if (mole_leds !== '0 || game_over !== 1'b1 || hit_pulse !== 1'b0 ||
          score !== SW'(exp_score) || misses !== SW'(exp_misses)) begin
        n_bad++;
        $display("FAIL done_frozen%0d: got leds=%b go=%b hit=%b score=%0d misses=%0d, expected 0/1/0/%0d/%0d",
                 i, mole_leds, game_over, hit_pulse, score, misses, exp_score, exp_misses);
      end
    end
    whack = '0;
    game_begin = 2'b00;
    step();
    step();
    exp_score = 0; exp_misses = 0;
    n_cmp++;
    if (score !== SW'(0) || misses !== SW'(0) || game_over !== 1'b0 || mole_leds !== '0) begin
      n_bad++;
      $display("FAIL back_to_idle: got score=%0d misses=%0d go=%b leds=%b, expected 0/0/0/0",
               score, misses, game_over, mole_leds);
    end
    game_begin = 2'b01;
    wait_mole(GAP_T + 1);
  endtask

  task automatic test_reset_mid();
    whack = '0;
    whack[cur_hole] = 1'b1;
    step();
    whack = '0;
    exp_score = sat_inc(exp_score);
    n_cmp++;
    if (score !== SW'(exp_score)) begin
      n_bad++;
      $display("FAIL pre_reset_hit: got score=%0d, expected %0d", score, exp_score);
    end
    wait_mole(GAP_T);
    #3;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({mole_leds, score, misses, hit_pulse, game_over} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got leds=%b score=%0d misses=%0d hit=%b go=%b, expected all 0",
               mole_leds, score, misses, hit_pulse, game_over);
    end
    step();
    step();
    n_cmp++;
    if ({mole_leds, score, misses, hit_pulse, game_over} !== '0) begin
      n_bad++;
      $display("FAIL reset_hold: got leds=%b score=%0d misses=%0d, expected all 0", mole_leds, score, misses);
    end
    reset = 1'b1;
    last_hole = -1; exp_score = 0; exp_misses = 0;
    wait_mole(GAP_T + 1);
    n_cmp++;
    if (score !== SW'(0) || misses !== SW'(0) || game_over !== 1'b0) begin
      n_bad++;
      $display("FAIL restart: got score=%0d misses=%0d go=%b, expected 0/0/0", score, misses, game_over);
    end
  endtask

  initial begin
    test_reset();
    test_first_mole();
    test_hit_and_hold();
    test_timeout();
    test_simultaneous();
    test_random(40);
    test_saturation();
    test_phase_override();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
